// File: rtl/count_window_streamer.sv
// count_window_streamer: counts discriminator event strobes over back-to-back
// windows of window_len clock cycles and streams {seq, count} per completed
// window through a first-word-fall-through FIFO onto an AXI-Stream master port.
// Optional feature macro: COUNT_WINDOW_SATURATE_EN (count saturates instead of
// wrapping within a window).
module count_window_streamer #(
  parameter int COUNT_WIDTH      = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int AXIS_TDATA_WIDTH = 16 + COUNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          event_in,
  input  logic                          enable,
  input  logic [31:0]                   window_len,
  output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_OUT_tdata,
  output logic                          M_AXIS_OUT_tvalid,
  input  logic                          M_AXIS_OUT_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                      state, state_next;
  logic [COUNT_WIDTH-1:0]      count, count_inc;
  logic [15:0]                 seq;
  logic [31:0]                 timer, window_load;
  logic                        start, push_req, push_ok, pop, full;
  logic [AXIS_TDATA_WIDTH-1:0] push_data;
  logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;

  // A window length of 0 or 1 both mean a single-cycle window.
  assign window_load = (window_len <= 32'd1) ? 32'd1 : window_len;

  // Per-cycle count update including the current strobe, so the last cycle counts.
`ifdef COUNT_WINDOW_SATURATE_EN
  assign count_inc = (event_in && (count != '1))
                     ? count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : count;
`else
  assign count_inc = count + {{(COUNT_WIDTH-1){1'b0}}, event_in};
`endif

  assign push_data         = AXIS_TDATA_WIDTH'({seq, count_inc});
  assign M_AXIS_OUT_tvalid = (fifo_level != '0);
  assign M_AXIS_OUT_tdata  = M_AXIS_OUT_tvalid ? mem[rd_ptr] : '0;
  assign pop               = M_AXIS_OUT_tvalid && M_AXIS_OUT_tready;
  assign full              = (fifo_level == LVL_FULL);
  assign push_ok           = push_req && (!full || pop);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus window start and window-complete strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = COUNT;
          start      = 1'b1;
        end
      end
      COUNT: begin
        if (!enable) state_next = IDLE;
        else if (timer == 32'd1) push_req = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window timer, event count and sequence number; a new window follows the last cycle directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      seq   <= '0;
      timer <= '0;
    end else if (start) begin
      count <= '0;
      seq   <= '0;
      timer <= window_load;
    end else if (state == COUNT && enable) begin
      if (timer == 32'd1) begin
        count <= '0;
        seq   <= seq + 16'd1;
        timer <= window_load;
      end else begin
        count <= count_inc;
        timer <= timer - 32'd1;
      end
    end
  end

  // Sticky drop flag, cleared only when a new run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overflow <= 1'b0;
    else if (start)                overflow <= 1'b0;
    else if (push_req && !push_ok) overflow <= 1'b1;
  end

  // FIFO pointers and occupancy; a push into a full FIFO is allowed when a pop frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because tdata is gated by tvalid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_count_window_streamer.sv
// Testbench for count_window_streamer: scoreboard of expected {seq, count}
// entries checked as the DUT hands them out, plus directed boundary checks.
module tb_count_window_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        event_in, enable, tready;
  logic [31:0] window_len;
  logic [31:0] tdata;
  logic        tvalid, overflow;
  logic [3:0]  fifo_level;

  logic        event4, enable4, tready4;
  logic [31:0] wlen4;
  logic [19:0] tdata4;
  logic        tvalid4, overflow4;
  logic [3:0]  fifo_level4;

  int          tests_run = 0;
  int          failures  = 0;
  logic [31:0] sb[$];

  count_window_streamer dut (
    .clk(clk), .rst(rst), .event_in(event_in), .enable(enable),
    .window_len(window_len), .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid),
    .M_AXIS_OUT_tready(tready), .fifo_level(fifo_level), .overflow(overflow)
  );

  count_window_streamer #(.COUNT_WIDTH(4), .FIFO_DEPTH(8), .AXIS_TDATA_WIDTH(20)) dut4 (
    .clk(clk), .rst(rst), .event_in(event4), .enable(enable4),
    .window_len(wlen4), .M_AXIS_OUT_tdata(tdata4), .M_AXIS_OUT_tvalid(tvalid4),
    .M_AXIS_OUT_tready(tready4), .fifo_level(fifo_level4), .overflow(overflow4)
  );

  // 125 MHz clock
  always #4 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pops the scoreboard whenever the DUT hands over an entry.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (sb.size() == 0) checkOutput("extra_entry", 32'(sb.size()), 32'd1);
      else checkOutput("stream_data", tdata, sb.pop_front());
    end
  end

  // Runs nwin full windows from IDLE; mode 0 = event every cycle, else random events.
  task automatic applyStimulus(input int wl, input int nwin, input int mode, input int rdy_win,
                               input bit pulse, input int drop_win, input bit chk_timing);
    int eff, cnt;
    bit ev;
    eff = (wl <= 1) ? 1 : wl;
    window_len = 32'(wl);
    enable = 1'b1;
    event_in = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < nwin; w++) begin
      cnt = 0;
      for (int c = 0; c < eff; c++) begin
        ev = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        event_in = ev;
        if (w == rdy_win && (pulse ? (c == eff - 1) : (c == 0))) tready = 1'b1;
        @(posedge clk); #1;
        cnt += int'(ev);
        if (chk_timing) checkOutput("tvalid_timing", 32'(tvalid), (c == eff - 1) ? 32'd1 : 32'd0);
        if (pulse && w == rdy_win && c == eff - 1) tready = 1'b0;
      end
      if (w != drop_win) sb.push_back({16'(w), 16'(cnt)});
    end
    enable = 1'b0;
    event_in = 1'b0;
  endtask

  // Lets the FIFO empty within a bounded number of cycles.
  task automatic drainFifo();
    tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (fifo_level == 4'd0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] sat_exp;
    rst = 1'b1; event_in = 1'b0; enable = 1'b0; tready = 1'b0; window_len = 32'd0;
    event4 = 1'b0; enable4 = 1'b0; tready4 = 1'b0; wlen4 = 32'd0;
    #10;
    checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_tdata", tdata, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic streaming: 10-cycle windows, event every cycle, tvalid exactly one cycle after each end.
    tready = 1'b1;
    applyStimulus(10, 3, 0, -1, 1'b0, -1, 1'b1);
    drainFifo();

    // Single-cycle windows for window_len 1 and 0 with random events.
    applyStimulus(1, 6, 1, -1, 1'b0, -1, 1'b0);
    drainFifo();
    applyStimulus(0, 4, 1, -1, 1'b0, -1, 1'b0);
    drainFifo();

    // Overflow: 8 stored, 9th dropped, then drain with seq 9 following seq 7.
    tready = 1'b0;
    applyStimulus(4, 10, 0, 9, 1'b0, 8, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    drainFifo();

    // Aborted window discards partial data; restart clears overflow.
    window_len = 32'd5;
    enable = 1'b1;
    @(posedge clk); #1;
    checkOutput("ovf_clear", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("abort_level", 32'(fifo_level), 32'd0);
    checkOutput("abort_tvalid", 32'(tvalid), 32'd0);
    applyStimulus(5, 1, 1, -1, 1'b0, -1, 1'b0);
    drainFifo();

    // Full FIFO with push and pop on the same edge.
    tready = 1'b0;
    applyStimulus(4, 9, 0, 8, 1'b1, -1, 1'b0);
    checkOutput("full_level", 32'(fifo_level), 32'd8);
    checkOutput("full_ovf", 32'(overflow), 32'd0);
    drainFifo();

    // 4-bit count over a 20-cycle window: saturate or wrap.
`ifdef COUNT_WINDOW_SATURATE_EN
    sat_exp = 32'h0000F;
`else
    sat_exp = 32'h00004;
`endif
    wlen4 = 32'd20; event4 = 1'b1; enable4 = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    enable4 = 1'b0; event4 = 1'b0;
    checkOutput("sat_tvalid", 32'(tvalid4), 32'd1);
    checkOutput("sat_count", 32'(tdata4), sat_exp);

    // Reset mid-window with three entries queued clears outputs immediately.
    tready = 1'b0;
    window_len = 32'd4;
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    checkOutput("pre_rst_level", 32'(fifo_level), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_tvalid", 32'(tvalid), 32'd0);
    checkOutput("async_level", 32'(fifo_level), 32'd0);
    checkOutput("async_tdata", tdata, 32'd0);
    enable = 1'b0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/count_window_streamer.md
COUNT_WINDOW_STREAMER -- requirements
Module: count_window_streamer

Interface
REQ-001: Parameter COUNT_WIDTH, default 16, SHALL set the per-window event count width.
REQ-002: Parameter FIFO_DEPTH, default 8, SHALL set the output FIFO depth in entries; power of two, minimum 2.
REQ-003: Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the output stream width; equals 16 + COUNT_WIDTH.
REQ-004: Port clk, input, 1 bit, SHALL be the single clock, 125 MHz, rising edge.
REQ-005: Port rst, input, 1 bit, SHALL be the reset: asynchronous assertion, active-high.
REQ-006: Port event_in, input, 1 bit, SHALL be a one-cycle strobe per detected photon edge from the discriminator stage.
REQ-007: Port enable, input, 1 bit, SHALL run the windowing while high.
REQ-008: Port window_len, input, 32 bits, SHALL give the window length in clk cycles.
REQ-009: Port M_AXIS_OUT_tdata, output, AXIS_TDATA_WIDTH bits, SHALL carry {seq[15:0], count}.
REQ-010: Port M_AXIS_OUT_tvalid, output, 1 bit, SHALL be high while the FIFO is non-empty.
REQ-011: Port M_AXIS_OUT_tready, input, 1 bit, SHALL be the downstream accept.
REQ-012: Port fifo_level, output, log2(FIFO_DEPTH)+1 bits, SHALL give the current FIFO occupancy.
REQ-013: Port overflow, output, 1 bit, SHALL be a sticky flag for a dropped window.

Function
REQ-014: The FSM SHALL have states IDLE and COUNT; IDLE->COUNT on a clk edge with enable=1; COUNT->IDLE on a clk edge with enable=0.
REQ-015: On IDLE->COUNT, the block SHALL clear count, seq and overflow, and load the cycle timer from window_len.
REQ-016: window_len SHALL be sampled only at each window start; window_len of 0 or 1 SHALL give 1-cycle windows.
REQ-017: A window SHALL span exactly window_len cycles in COUNT; every event_in=1 cycle inside it SHALL add 1, including the last cycle.
REQ-018: At the last-cycle edge, the block SHALL push {seq, final count} and increment seq (16-bit wrap); the next window SHALL start the following cycle with count 0, with no gap cycles.
REQ-019: Deasserting enable mid-window SHALL discard the partial window with no push; FIFO contents SHALL be retained and keep draining.
REQ-020: The FIFO SHALL be first-word-fall-through: tdata = head entry whenever tvalid=1, held stable until tvalid&&tready.
REQ-021: An entry pushed into an empty FIFO SHALL appear on tvalid in the cycle after the push edge (1-cycle latency).
REQ-022: A pop SHALL occur on each edge with tvalid&&tready.
REQ-023: A push SHALL succeed if the FIFO is not full, or if it is full and a pop occurs on the same edge (level unchanged).
REQ-024: When full with no same-edge pop, a push SHALL drop the window and set overflow; seq SHALL still increment so the gap is visible.
REQ-025: A pop from an empty FIFO SHALL have no effect; fifo_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-026: rst=1 SHALL immediately set: state IDLE, count 0, seq 0, timer 0, FIFO empty, tvalid 0, tdata 0, fifo_level 0, overflow 0.
REQ-027: Release SHALL be synchronous to clk; the first IDLE->COUNT is possible on the first edge after release with enable=1.
REQ-028: rst mid-window or with a non-empty FIFO SHALL discard all data; no partial entry SHALL be emitted.

Configuration
REQ-029: Macro COUNT_WINDOW_SATURATE_EN defined: count SHALL saturate at 2^COUNT_WIDTH-1 within a window. Undefined: count SHALL wrap to 0.

Verification
REQ-030: window_len=10, enable high, event_in high every cycle, tready=1 -> entries {0,10},{1,10},{2,10}; tvalid 1 cycle after each window end.
REQ-031: window_len=4, tready=0, FIFO_DEPTH=8 -> 8 entries stored, 9th window dropped, overflow=1; on tready=1 seq 0..7 drain, then seq 9 follows.
REQ-032: window_len=5, enable dropped at cycle 3 of window 0 -> no entry pushed; re-enable -> first entry seq 0, overflow cleared.
REQ-033: COUNT_WIDTH=4, window_len=20, event_in every cycle -> count 15 with COUNT_WINDOW_SATURATE_EN, count 4 without.
REQ-034: FIFO full with a push and tready=1 on the same edge -> push accepted, fifo_level stays 8, overflow stays 0.
REQ-035: rst pulse mid-window with 3 entries queued -> tvalid=0 and fifo_level=0 immediately, before the next clk edge.
